// File: rtl/dili_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dili_pkg
//  Description : Shared mode encoding and reduction constants for the
//                Dilithium freeze pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package dili_pkg;

    // Per-beat operating mode, carried alongside its data through the pipe
    typedef enum logic [1:0] {
        FRZ_FREEZE = 2'd0,
        FRZ_REDUCE = 2'd1,
        FRZ_CADDQ  = 2'd2,
        FRZ_PASS   = 2'd3
    } dili_frz_mode_e;

    // Rounding shift used to estimate the quotient t = round(a / 2^23)
    localparam int REDUCE_SHIFT = 23;
    localparam int REDUCE_RND   = 1 << 22;

    // Largest input for which a + REDUCE_RND cannot overflow 32 bits
    localparam int RANGE_LIMIT  = 2143289343;

endpackage
`default_nettype wire

// File: rtl/dili_freeze_lane.sv
`default_nettype none
// ============================================================================
//  Module      : dili_freeze_lane
//  Description : Combinational single-lane datapath: reduce32 step, conditional
//                add of Q, and input range detection, each gated by the mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module dili_freeze_lane
    import dili_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int Q     = 8380417
) (
    input  logic [WIDTH-1:0] a,
    input  dili_frz_mode_e   mode,
    output logic [WIDTH-1:0] reduce_res,
    output logic [WIDTH-1:0] caddq_res,
    output logic             rng_err
);

    localparam logic [WIDTH-1:0] C_RND   = WIDTH'(REDUCE_RND);
    localparam logic [WIDTH-1:0] C_Q     = WIDTH'(Q);
    localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(RANGE_LIMIT);

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_t;
    logic [2*WIDTH-1:0] w_tq;
    logic [WIDTH-1:0]   w_tq_unused_hi;
    logic [WIDTH-1:0]   w_reduced;
    logic [WIDTH-1:0]   w_caddq;
    logic               w_do_reduce;
    logic               w_do_caddq;

    // Quotient estimate, product at double width, remainder truncated back
    always_comb begin
        w_sum          = a + C_RND;
        w_t            = WIDTH'($signed(w_sum) >>> REDUCE_SHIFT);
        // Sign-extended t times zero-extended Q is exact modulo 2^(2*WIDTH)
        w_tq           = {{WIDTH{w_t[WIDTH-1]}}, w_t} * {{WIDTH{1'b0}}, C_Q};
        w_tq_unused_hi = w_tq[2*WIDTH-1:WIDTH];
        w_reduced      = a - w_tq[WIDTH-1:0];
        w_caddq        = a + (a[WIDTH-1] ? C_Q : '0);
    end

    // Mode gating: unselected operations pass the operand through untouched
    always_comb begin
        w_do_reduce = (mode == FRZ_FREEZE) || (mode == FRZ_REDUCE);
        w_do_caddq  = (mode == FRZ_FREEZE) || (mode == FRZ_CADDQ);
        reduce_res  = w_do_reduce ? w_reduced : a;
        caddq_res   = w_do_caddq  ? w_caddq   : a;
        rng_err     = w_do_reduce && ($signed(a) > $signed(C_LIMIT));
    end

endmodule
`default_nettype wire

// File: rtl/dili_freeze_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dili_freeze_pipe
//  Description : Two-stage, multi-lane freeze pipeline with valid/ready
//                handshake, per-beat mode and sticky input-range error.
//                Stage 1 applies reduce32, stage 2 applies caddq.
//                WIDTH must be at least 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module dili_freeze_pipe
    import dili_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int Q     = 8380417
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [1:0]             mode_i,
    input  logic [LANES*WIDTH-1:0] a_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES*WIDTH-1:0] a_o,
    output logic                   rng_err_o,
    input  logic                   clr_err_i
);

    logic                   r_s1_valid;
    dili_frz_mode_e         r_s1_mode;
    logic [LANES*WIDTH-1:0] r_s1_data;
    logic                   r_s2_valid;
    logic [LANES*WIDTH-1:0] r_s2_data;
    logic                   r_rng_err;

    logic                   w_adv2;
    logic                   w_adv1;
    logic                   w_in_hs;
    dili_frz_mode_e         w_in_mode;
    logic [LANES*WIDTH-1:0] w_s1_next;
    logic [LANES*WIDTH-1:0] w_s2_next;
    logic [LANES-1:0]       w_lane_err;

    // Outputs of the lane instances that a given stage does not need
    logic [LANES*WIDTH-1:0] w_s1_caddq_unused;
    logic [LANES*WIDTH-1:0] w_s2_reduce_unused;
    logic [LANES-1:0]       w_s2_err_unused;

    // Handshake: a stage advances when it is empty or its successor advances
    always_comb begin
        w_adv2    = ~r_s2_valid | out_ready_i;
        w_adv1    = ~r_s1_valid | w_adv2;
        w_in_hs   = in_valid_i & w_adv1;
        w_in_mode = dili_frz_mode_e'(mode_i);
    end

    assign in_ready_o  = w_adv1;
    assign out_valid_o = r_s2_valid;
    assign a_o         = r_s2_data;
    assign rng_err_o   = r_rng_err;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            dili_freeze_lane #(
                .WIDTH (WIDTH),
                .Q     (Q)
            ) u_s1_lane (
                .a          (a_i[k*WIDTH +: WIDTH]),
                .mode       (w_in_mode),
                .reduce_res (w_s1_next[k*WIDTH +: WIDTH]),
                .caddq_res  (w_s1_caddq_unused[k*WIDTH +: WIDTH]),
                .rng_err    (w_lane_err[k])
            );

            dili_freeze_lane #(
                .WIDTH (WIDTH),
                .Q     (Q)
            ) u_s2_lane (
                .a          (r_s1_data[k*WIDTH +: WIDTH]),
                .mode       (r_s1_mode),
                .reduce_res (w_s2_reduce_unused[k*WIDTH +: WIDTH]),
                .caddq_res  (w_s2_next[k*WIDTH +: WIDTH]),
                .rng_err    (w_s2_err_unused[k])
            );
        end
    endgenerate

    // Stage 1 register: reduced data plus the mode that travels with it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= FRZ_FREEZE;
            r_s1_data  <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid_i;
            if (in_valid_i) begin
                r_s1_mode <= w_in_mode;
                r_s1_data <= w_s1_next;
            end
        end
    end

    // Stage 2 register: final result, held while downstream stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_s2_next;
            end
        end
    end

    // Sticky range error: a new error on an accepted beat beats the clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rng_err <= 1'b0;
        end else if (w_in_hs && (|w_lane_err)) begin
            r_rng_err <= 1'b1;
        end else if (clr_err_i) begin
            r_rng_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dili_freeze_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dili_freeze_pipe
//  Description : Self-checking bench for dili_freeze_pipe: vector table,
//                reference model, output scoreboard and corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dili_freeze_pipe;

    localparam int W  = 32;
    localparam int L  = 4;
    localparam int QM = 8380417;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     mode;
    logic [L*W-1:0] a_in;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] a_out;
    logic           rng_err;
    logic           clr_err;

    logic [L*W-1:0] pending_exp;
    logic [L*W-1:0] exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             rx_count = 0;

    always #5 clk = ~clk;

    dili_freeze_pipe #(
        .WIDTH (W),
        .LANES (L),
        .Q     (QM)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .a_i         (a_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .a_o         (a_out),
        .rng_err_o   (rng_err),
        .clr_err_i   (clr_err)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a [L];
        logic [31:0] e [L];
    } vec_t;

    // Reference: floor-division quotient estimate on a 32-bit wrapped sum
    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] a);
        logic [31:0] sum32;
        longint      s;
        longint      t;
        longint      r;
        logic [31:0] res;
        res = a;
        if (m == 2'd0 || m == 2'd1) begin
            sum32 = a + 32'd4194304;
            s     = longint'($signed(sum32));
            t     = (s >= 0) ? (s / 8388608) : -((-s + 8388607) / 8388608);
            r     = longint'($signed(a)) - t * longint'(QM);
            res   = r[31:0];
        end
        if (m == 2'd0 || m == 2'd2) begin
            if ($signed(res) < 0) res = res + 32'(QM);
        end
        return res;
    endfunction

    function automatic logic [L*W-1:0] model_beat(input logic [1:0] m, input logic [L*W-1:0] a);
        logic [L*W-1:0] r;
        for (int k = 0; k < L; k++) r[k*W +: W] = model(m, a[k*W +: W]);
        return r;
    endfunction

    task automatic check(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: record accepted beats, compare each delivered beat in order
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(pending_exp);
            if (out_valid && out_ready) begin
                rx_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none", a_out);
                end else begin
                    logic [L*W-1:0] e;
                    e = exp_q.pop_front();
                    if (a_out !== e) begin
                        errors++;
                        $display("FAIL beat_data actual=%h required=%h", a_out, e);
                    end
                end
            end
        end
    end

    // Present one beat from posedge+1 and hold until it is accepted
    task automatic send(input logic [1:0] m, input logic [L*W-1:0] a, input logic [L*W-1:0] e);
        int n = 0;
        in_valid    = 1'b1;
        mode        = m;
        a_in        = a;
        pending_exp = e;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("drain_empty", L*W'(exp_q.size()), '0);
    endtask

    function automatic logic [L*W-1:0] pack(input logic [31:0] v [L]);
        logic [L*W-1:0] r;
        for (int k = 0; k < L; k++) r[k*W +: W] = v[k];
        return r;
    endfunction

    vec_t           vecs [5];
    logic [L*W-1:0] held;
    logic [L*W-1:0] big;
    int             rx_base;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 2'd0;
        a_in      = '0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        pending_exp = '0;

        vecs[0] = '{2'd0, '{32'(QM), 32'hFFFF_FFFF, 32'd0, 32'(QM-1)},
                          '{32'd0, 32'(QM-1), 32'd0, 32'(QM-1)}};
        vecs[1] = '{2'd0, '{32'd2143289343, 32'h8000_0000, 32'd0, 32'd1},
                          '{32'd6283008, 32'd6283521, 32'd0, 32'd1}};
        vecs[2] = '{2'd1, '{32'd8380418, 32'hFFFF_FFFF, 32'd0, 32'(QM)},
                          '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0}};
        vecs[3] = '{2'd2, '{32'hFFFF_FFFB, 32'd5, 32'(QM), 32'(-QM)},
                          '{32'd8380412, 32'd5, 32'(QM), 32'd0}};
        vecs[4] = '{2'd3, '{32'hFFFF_FFFB, 32'd1, 32'd2, 32'd3},
                          '{32'hFFFF_FFFB, 32'd1, 32'd2, 32'd3}};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_out_valid", L*W'(out_valid), '0);
        check("reset_a_o", a_out, '0);
        check("reset_rng_err", L*W'(rng_err), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", L*W'(in_ready), L*W'(1));

        // Vector table, issued back-to-back
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(vecs[i].mode, pack(vecs[i].a), pack(vecs[i].e));
        drain();
        check("no_err_in_range", L*W'(rng_err), '0);

        // Sticky range error and clear behaviour
        big = '0;
        big[31:0] = 32'h7FFF_FFFF;
        send(2'd0, big, model_beat(2'd0, big));
        check("err_set", L*W'(rng_err), L*W'(1));
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", L*W'(rng_err), L*W'(1));
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("err_cleared", L*W'(rng_err), '0);
        clr_err = 1'b1;
        send(2'd1, big, model_beat(2'd1, big));
        clr_err = 1'b0;
        check("err_set_beats_clear", L*W'(rng_err), L*W'(1));
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        send(2'd3, big, big);
        send(2'd2, big, model_beat(2'd2, big));
        check("no_err_pass_caddq", L*W'(rng_err), '0);
        drain();

        // Backpressure: 8 beats while downstream stalls for 5 cycles
        rx_base   = rx_count;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [L*W-1:0] a;
                    logic [1:0]     m;
                    m = 2'(i % 4);
                    for (int k = 0; k < L; k++)
                        a[k*W +: W] = $urandom_range(32'd4000000000, 32'd0) - 32'd2000000000;
                    send(m, a, model_beat(m, a));
                end
            end
        join_none
        repeat (3) @(negedge clk);
        check("bp_ready_low", L*W'(in_ready), '0);
        check("bp_valid_high", L*W'(out_valid), L*W'(1));
        held = a_out;
        repeat (2) begin
            @(negedge clk);
            check("bp_data_stable", a_out, held);
            check("bp_ready_still_low", L*W'(in_ready), '0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain();
        check("bp_count", L*W'(rx_count - rx_base), L*W'(8));

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        send(2'd0, big, model_beat(2'd0, big));
        send(2'd3, '0, '0);
        @(negedge clk);
        check("flight_valid", L*W'(out_valid), L*W'(1));
        check("flight_err", L*W'(rng_err), L*W'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_valid_drop", L*W'(out_valid), '0);
        check("async_err_clear", L*W'(rng_err), '0);
        exp_q.delete();
        rx_base = rx_count;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_stale_beat", L*W'(rx_count - rx_base), '0);
        check("post_reset_ready", L*W'(in_ready), L*W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dili_freeze_pipe.md
# dili_freeze_pipe

Pipelined, multi-lane successor of the Dilithium freeze datapath: maps signed coefficients to the canonical range [0, Q) through a 32-bit reduction stage followed by a conditional add of Q. The mode is selectable per beat. Sits between the NTT/pointwise units and the packing logic. Uses a valid/ready stream with full throughput and backpressure, and flags out-of-range inputs with a sticky error bit.

## Interface
- WIDTH, 32: coefficient width in bits; must be ≥ 32.
- LANES, 4: coefficients processed per beat.
- Q, 8380417: modulus.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset; asynchronous and active-low.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat.
- mode_i  in  2  per-beat mode: 0 FREEZE, 1 REDUCE, 2 CADDQ, 3 PASS.
- a_i  in  LANES*WIDTH  signed coefficients; lane k is at [k*WIDTH +: WIDTH].
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts.
- a_o  out  LANES*WIDTH  result coefficients, same lane order.
- rng_err_o  out  1  sticky input-range error.
- clr_err_i  in  1  clears rng_err_o.

## Operation
- REDUCE, per lane: t = (a + 2^22) >>> 23; r = a − t·Q.
  - Compute t·Q at 2·WIDTH bits, then truncate r to WIDTH.
- CADDQ, per lane: r = a + (sign(a) ? Q : 0).
- FREEZE: REDUCE, then CADDQ. Result is in [0, Q) for any in-range input.
- PASS: r = a, unchanged.
- Stage 1 applies REDUCE when mode is FREEZE or REDUCE; otherwise it passes the value through. Stage 2 applies CADDQ when mode is FREEZE or CADDQ; otherwise it passes through.
- The mode travels with its beat. Beats with different modes may be back-to-back.
- Range check applies only to FREEZE and REDUCE beats. Any lane with a > 2^31 − 2^22 − 1 on an accepted beat sets rng_err_o the next cycle.
  - Such a beat is still processed. Its result is the truncated value.
- rng_err_o stays set until a cycle with clr_err_i = 1.
  - If clear and a new error occur in the same cycle, the set wins.

## Timing
- Reset: all valids 0, stage data 0, out_valid_o 0, a_o 0, rng_err_o 0.
  - in_ready_o is 1 from the first cycle after reset release.
- Latency: exactly 2 cycles from input handshake (in_valid_i & in_ready_o) to out_valid_o.
- Throughput: 1 beat/cycle while out_ready_i = 1.
- Stage 2 advances when ~s2_valid | out_ready_i (adv2).
- Stage 1 advances when ~s1_valid | adv2.
- in_ready_o = ~s1_valid | adv2. It is combinational from out_ready_i and has no combinational path from in_valid_i.
- While out_valid_o = 1 and out_ready_i = 0, a_o and out_valid_o hold stable. A full pipe holds 2 beats; in_ready_o drops only when both stages are full and out_ready_i = 0.
- out_valid_o never depends combinationally on in_valid_i.
- Asynchronous reset mid-stream drops all in-flight beats with no output. The sticky error is also cleared.

## Structure
- Package dili_pkg holds:
  - mode enum dili_frz_mode_e (FRZ_FREEZE, FRZ_REDUCE, FRZ_CADDQ, FRZ_PASS);
  - localparams REDUCE_SHIFT = 23 and REDUCE_RND = 2^22;
  - the range limit 2^31 − 2^22 − 1.
- Sub-module dili_freeze_lane: combinational, one lane. Inputs are the stage-1 or stage-2 operand and the mode; it outputs the reduce result, the caddq result and the per-lane range-error bit. Instantiate it LANES times by generate.
- The top level owns the two pipeline registers, the handshake and the sticky flag.

## Test plan
- FREEZE, lanes {Q, −1, 0, Q−1} -> a_o {0, Q−1, 0, Q−1} two cycles after the handshake; rng_err_o = 0.
- FREEZE on lane 0 with 2^31 − 2^22 − 1 = 2143289343 -> 6283008. FREEZE on lane 0 with −2^31 -> 6283521. rng_err_o stays 0.
- REDUCE with a = 8380418 -> 1. CADDQ with a = −5 -> 8380412. PASS with a = −5 -> −5. Issue all three back-to-back; each result keeps its own mode.
- FREEZE with a = 2^31 − 1 -> rng_err_o = 1 the next cycle and stays 1. Pulsing clr_err_i clears it. A new error in the same cycle as clr_err_i leaves it at 1.
- Backpressure: stream 8 beats with out_ready_i = 0 for 5 cycles. After 2 beats in_ready_o = 0 and a_o is stable. Once out_ready_i returns to 1, all 8 results come out in order with no loss or duplication.
- Assert rst_ni low while 2 beats are in flight -> out_valid_o = 0 immediately. No stale beat appears after release.
